// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store back end: issue FSM encoding,
// bus op constants, store-buffer entry layout and default tag width.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUS_RD    = 2'd1,
        BUS_WR_SB = 2'd2,
        BUS_WR_WB = 2'd3
    } lsu_state_e;

    localparam logic BUS_OP_RD = 1'b0;
    localparam logic BUS_OP_WR = 1'b1;

    localparam int DEFAULT_TAG_W = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } sb_entry_t;

endpackage

// File: rtl/lsu_store_path_if.sv
// Single-port memory bus between the LSU (master) and memory (slave).
// Handshake: master raises mem_req with mem_we/mem_addr/mem_data_out and holds
// them stable until the cycle mem_rdy=1; that cycle completes the transfer and
// read data is valid on mem_data_in in the same cycle.
interface lsu_store_path_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        mem_rdy;
    logic [15:0] mem_data_in;

    modport master (
        output mem_req, mem_we, mem_addr, mem_data_out,
        input  mem_rdy, mem_data_in
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_data_out,
        output mem_rdy, mem_data_in
    );
endinterface

// File: rtl/lsu_store_fifo.sv
// Store buffer: circular FIFO of {addr,data} with wrap-bit pointers and a
// parallel youngest-match address lookup used for store-to-load forwarding.
module lsu_store_fifo
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        push,
    input  sb_entry_t   push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output sb_entry_t   head,
    input  logic [15:0] lookup_addr,
    output logic        hit,
    output logic [15:0] hit_data
);

    localparam int PW    = $clog2(SB_DEPTH);
    localparam int PTR_W = PW + 1;

    sb_entry_t          entries [SB_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   count;
    logic [PW-1:0]      idx;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr[PW-1:0]] <= push_entry;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = entries[rd_ptr[PW-1:0]];

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr[PW-1:0] + PW'(i);
            if ((PTR_W'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/lsu_store_path.sv
// LSU back end: accepts scheduler loads/stores, buffers stores, captures RMW
// write-backs, forwards buffered data to loads and runs one bus op at a time.
module lsu_store_path
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = DEFAULT_TAG_W
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              sched_req,
    input  logic              sched_we,
    input  logic [TAG_W-1:0]  sched_tag,
    input  logic [15:0]       sched_data,
    input  logic [15:0]       agu_addr,
    output logic              sched_stall,
    input  logic [15:0]       rmw_addr,
    input  logic [15:0]       rmw_data,
    input  logic              rmw_data_rdy,
    input  logic              rmw_deny_op,
    output logic              rmw_hold,
    lsu_store_path_if.master  bus,
    output logic              rf_wr,
    output logic [TAG_W-1:0]  rf_tag,
    output logic [15:0]       rf_data,
    output lsu_state_e        state_dbg
);

    lsu_state_e        state, state_d;
    logic              wb_valid;
    logic [15:0]       wb_addr, wb_data;
    logic              load_pending;
    logic [TAG_W-1:0]  ld_tag;
    logic [15:0]       ld_addr;

    logic              sb_full, sb_empty, sb_hit, sb_push, sb_pop;
    logic [15:0]       sb_hit_data;
    sb_entry_t         sb_head, push_entry;

    logic              accept, wb_capture, bus_done;
    logic              issue, issue_we;
    logic [15:0]       issue_addr, issue_data;

    assign push_entry.addr = agu_addr;
    assign push_entry.data = sched_data;

    lsu_store_fifo #(.SB_DEPTH(SB_DEPTH)) u_store_fifo (
        .clk         (clk),
        .a_rst       (a_rst),
        .push        (sb_push),
        .push_entry  (push_entry),
        .pop         (sb_pop),
        .full        (sb_full),
        .empty       (sb_empty),
        .head        (sb_head),
        .lookup_addr (agu_addr),
        .hit         (sb_hit),
        .hit_data    (sb_hit_data)
    );

    // Loads wait behind a pending load or a queued write-back to the same address.
    assign sched_stall = sched_req & (rmw_deny_op
                                    | (sched_we & sb_full)
                                    | (~sched_we & (load_pending | (wb_valid & (wb_addr == agu_addr)))));
    assign accept      = sched_req & ~sched_stall;
    assign sb_push     = accept & sched_we;
    assign rmw_hold    = rmw_data_rdy & wb_valid;
    assign wb_capture  = rmw_data_rdy & ~wb_valid;
    assign bus_done    = bus.mem_rdy & (state != IDLE);
    assign sb_pop      = bus_done & (state == BUS_WR_SB);
    assign state_dbg   = state;

    always_comb begin
        state_d    = state;
        issue      = 1'b0;
        issue_we   = BUS_OP_RD;
        issue_addr = '0;
        issue_data = '0;
        case (state)
            IDLE: begin
                if (wb_valid) begin
                    state_d    = BUS_WR_WB;
                    issue      = 1'b1;
                    issue_we   = BUS_OP_WR;
                    issue_addr = wb_addr;
                    issue_data = wb_data;
                end else if (load_pending) begin
                    state_d    = BUS_RD;
                    issue      = 1'b1;
                    issue_addr = ld_addr;
                end else if (!sb_empty) begin
                    state_d    = BUS_WR_SB;
                    issue      = 1'b1;
                    issue_we   = BUS_OP_WR;
                    issue_addr = sb_head.addr;
                    issue_data = sb_head.data;
                end
            end
            default: begin
                if (bus.mem_rdy) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state            <= IDLE;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_out <= '0;
        end else begin
            state <= state_d;
            if (issue) begin
                bus.mem_req      <= 1'b1;
                bus.mem_we       <= issue_we;
                bus.mem_addr     <= issue_addr;
                bus.mem_data_out <= issue_data;
            end else if (bus_done) begin
                bus.mem_req      <= 1'b0;
                bus.mem_we       <= 1'b0;
                bus.mem_addr     <= '0;
                bus.mem_data_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (wb_capture) begin
            wb_valid <= 1'b1;
            wb_addr  <= rmw_addr;
            wb_data  <= rmw_data;
        end else if (bus_done && state == BUS_WR_WB) begin
            wb_valid <= 1'b0;
        end
    end

    // A forward and a read completion never coincide: loads are accepted only with none pending.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            load_pending <= 1'b0;
            ld_tag       <= '0;
            ld_addr      <= '0;
            rf_wr        <= 1'b0;
            rf_tag       <= '0;
            rf_data      <= '0;
        end else begin
            rf_wr <= 1'b0;
            if (accept && !sched_we) begin
                if (sb_hit) begin
                    rf_wr   <= 1'b1;
                    rf_tag  <= sched_tag;
                    rf_data <= sb_hit_data;
                end else begin
                    load_pending <= 1'b1;
                    ld_tag       <= sched_tag;
                    ld_addr      <= agu_addr;
                end
            end
            if (bus_done && state == BUS_RD) begin
                load_pending <= 1'b0;
                rf_wr        <= 1'b1;
                rf_tag       <= ld_tag;
                rf_data      <= bus.mem_data_in;
            end
        end
    end

endmodule

// File: tb/tb_lsu_store_path.sv
// Directed bench for lsu_store_path: forwarding, buffer full, issue priority,
// write-back hold, RMW deny and reset during a bus read.
module tb_lsu_store_path;
    import lsu_pkg::*;

    localparam int TAG_W = 3;

    logic              clk = 1'b0;
    logic              a_rst;
    logic              sched_req, sched_we;
    logic [TAG_W-1:0]  sched_tag;
    logic [15:0]       sched_data, agu_addr;
    logic              sched_stall;
    logic [15:0]       rmw_addr, rmw_data;
    logic              rmw_data_rdy, rmw_deny_op, rmw_hold;
    logic              rf_wr;
    logic [TAG_W-1:0]  rf_tag;
    logic [15:0]       rf_data;
    lsu_state_e        state_dbg;

    int checks = 0;
    int errors = 0;

    lsu_store_path_if bus ();

    lsu_store_path #(.SB_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .sched_req    (sched_req),
        .sched_we     (sched_we),
        .sched_tag    (sched_tag),
        .sched_data   (sched_data),
        .agu_addr     (agu_addr),
        .sched_stall  (sched_stall),
        .rmw_addr     (rmw_addr),
        .rmw_data     (rmw_data),
        .rmw_data_rdy (rmw_data_rdy),
        .rmw_deny_op  (rmw_deny_op),
        .rmw_hold     (rmw_hold),
        .bus          (bus.master),
        .rf_wr        (rf_wr),
        .rf_tag       (rf_tag),
        .rf_data      (rf_data),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        sched_req = 0; sched_we = 0; sched_tag = '0; sched_data = '0; agu_addr = '0;
        rmw_addr = '0; rmw_data = '0; rmw_data_rdy = 0; rmw_deny_op = 0;
        bus.mem_rdy = 0; bus.mem_data_in = '0;
    endtask

    // One-cycle scheduler request; returns the stall seen in that cycle.
    task automatic sched_op(input logic we, input logic [TAG_W-1:0] tag,
                            input logic [15:0] addr, input logic [15:0] data,
                            output logic stalled);
        @(negedge clk);
        sched_req = 1; sched_we = we; sched_tag = tag; agu_addr = addr; sched_data = data;
        #1 stalled = sched_stall;
        @(negedge clk);
        sched_req = 0;
    endtask

    task automatic wait_mem_req(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.mem_req) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic bus_ack(input logic [15:0] rdata);
        bus.mem_rdy = 1; bus.mem_data_in = rdata;
        @(negedge clk);
        bus.mem_rdy = 0; bus.mem_data_in = '0;
    endtask

    task automatic test_reset();
        a_rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0000", bus.mem_addr); end
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL rst_rf_wr: got %b expected 0", rf_wr); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, IDLE); end
        a_rst = 0;
        @(negedge clk);
        checks++; if (sched_stall !== 1'b0 || rmw_hold !== 1'b0) begin errors++; $display("FAIL rst_stall_hold: got %b%b expected 00", sched_stall, rmw_hold); end
    endtask

    task automatic test_forward();
        logic st;
        bit seen;
        sched_op(1, '0, 16'h0040, 16'h1234, st);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL fwd_store_stall: got %b expected 0", st); end
        sched_op(0, 3'd2, 16'h0040, 16'h0000, st);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL fwd_load_stall: got %b expected 0", st); end
        checks++; if (rf_wr !== 1'b1) begin errors++; $display("FAIL fwd_rf_wr: got %b expected 1", rf_wr); end
        checks++; if (rf_tag !== 3'd2) begin errors++; $display("FAIL fwd_rf_tag: got %0d expected 2", rf_tag); end
        checks++; if (rf_data !== 16'h1234) begin errors++; $display("FAIL fwd_rf_data: got %h expected 1234", rf_data); end
        // The only bus op in flight is the buffered store draining, never a read.
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0040 || bus.mem_data_out !== 16'h1234) begin
            errors++; $display("FAIL fwd_store_write: got req=%b we=%b addr=%h data=%h expected 1 1 0040 1234", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_data_out);
        end
        bus_ack(16'h0000);
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL fwd_rf_wr_pulse: got %b expected 0", rf_wr); end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_req) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fwd_no_read: got mem_req seen=%b expected 0", seen); end
    endtask

    task automatic test_fill();
        logic st;
        bit ok;
        logic [15:0] exp_addr, exp_data;
        for (int k = 0; k < 4; k++) begin
            sched_op(1, '0, 16'h1000 + 16'(2 * k), 16'hA000 + 16'(k), st);
            checks++; if (st !== 1'b0) begin errors++; $display("FAIL fill_store%0d_stall: got %b expected 0", k, st); end
        end
        @(negedge clk);
        sched_req = 1; sched_we = 1; agu_addr = 16'h1008; sched_data = 16'hA004;
        #1;
        checks++; if (sched_stall !== 1'b1) begin errors++; $display("FAIL fill_full_stall: got %b expected 1", sched_stall); end
        for (int k = 0; k < 5; k++) begin
            exp_addr = 16'h1000 + 16'(2 * k);
            exp_data = 16'hA000 + 16'(k);
            wait_mem_req(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL fill_wait%0d: got no mem_req expected mem_req within 20 cycles", k); end
            checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_addr || bus.mem_data_out !== exp_data) begin
                errors++; $display("FAIL fill_order%0d: got we=%b addr=%h data=%h expected 1 %h %h", k, bus.mem_we, bus.mem_addr, bus.mem_data_out, exp_addr, exp_data);
            end
            bus_ack(16'h0000);
            if (k == 0) begin
                #1;
                checks++; if (sched_stall !== 1'b0) begin errors++; $display("FAIL fill_accept5: got stall %b expected 0", sched_stall); end
                @(negedge clk);
                sched_req = 0;
            end
        end
    endtask

    task automatic test_deny();
        bit ok;
        @(negedge clk);
        sched_req = 1; sched_we = 0; sched_tag = 3'd1; agu_addr = 16'h0080; rmw_deny_op = 1;
        #1;
        checks++; if (sched_stall !== 1'b1) begin errors++; $display("FAIL deny_stall0: got %b expected 1", sched_stall); end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (sched_stall !== 1'b1) begin errors++; $display("FAIL deny_stall%0d: got %b expected 1", i, sched_stall); end
        end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL deny_no_issue: got %b expected 0", bus.mem_req); end
        @(negedge clk);
        rmw_deny_op = 0;
        #1;
        checks++; if (sched_stall !== 1'b0) begin errors++; $display("FAIL deny_release: got %b expected 0", sched_stall); end
        @(negedge clk);
        sched_req = 0;
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0080) begin
            errors++; $display("FAIL deny_read: got ok=%b we=%b addr=%h expected 1 0 0080", ok, bus.mem_we, bus.mem_addr);
        end
        bus_ack(16'h0000);
        checks++; if (rf_wr !== 1'b1 || rf_tag !== 3'd1 || rf_data !== 16'h0000) begin
            errors++; $display("FAIL deny_result: got wr=%b tag=%0d data=%h expected 1 1 0000", rf_wr, rf_tag, rf_data);
        end
    endtask

    task automatic test_priority();
        logic st;
        bit ok;
        sched_op(1, '0, 16'h0200, 16'h5555, st);
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_addr !== 16'h0200) begin errors++; $display("FAIL prio_store_issue: got ok=%b addr=%h expected 1 0200", ok, bus.mem_addr); end
        sched_op(0, 3'd5, 16'h0100, 16'h0000, st);
        checks++; if (st !== 1'b0 || rf_wr !== 1'b0) begin errors++; $display("FAIL prio_load_pending: got stall=%b rf_wr=%b expected 0 0", st, rf_wr); end
        @(negedge clk);
        rmw_addr = 16'h0080; rmw_data = 16'hBEEF; rmw_data_rdy = 1;
        #1;
        checks++; if (rmw_hold !== 1'b0) begin errors++; $display("FAIL prio_capture: got hold %b expected 0", rmw_hold); end
        @(negedge clk);
        rmw_data_rdy = 0;
        bus_ack(16'h0000);
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0080 || bus.mem_data_out !== 16'hBEEF) begin
            errors++; $display("FAIL prio_wb_first: got ok=%b we=%b addr=%h data=%h expected 1 1 0080 beef", ok, bus.mem_we, bus.mem_addr, bus.mem_data_out);
        end
        bus_ack(16'h0000);
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0100) begin
            errors++; $display("FAIL prio_read_second: got ok=%b we=%b addr=%h expected 1 0 0100", ok, bus.mem_we, bus.mem_addr);
        end
        bus_ack(16'hCAFE);
        checks++; if (rf_wr !== 1'b1 || rf_tag !== 3'd5 || rf_data !== 16'hCAFE) begin
            errors++; $display("FAIL prio_result: got wr=%b tag=%0d data=%h expected 1 5 cafe", rf_wr, rf_tag, rf_data);
        end
    endtask

    task automatic test_hold();
        bit ok;
        @(negedge clk);
        rmw_addr = 16'h0300; rmw_data = 16'h1111; rmw_data_rdy = 1;
        #1;
        checks++; if (rmw_hold !== 1'b0) begin errors++; $display("FAIL hold_first: got %b expected 0", rmw_hold); end
        @(negedge clk);
        rmw_addr = 16'h0304; rmw_data = 16'h2222;
        #1;
        checks++; if (rmw_hold !== 1'b1) begin errors++; $display("FAIL hold_second: got %b expected 1", rmw_hold); end
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_addr !== 16'h0300 || bus.mem_data_out !== 16'h1111) begin
            errors++; $display("FAIL hold_wb1: got ok=%b addr=%h data=%h expected 1 0300 1111", ok, bus.mem_addr, bus.mem_data_out);
        end
        bus_ack(16'h0000);
        #1;
        checks++; if (rmw_hold !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", rmw_hold); end
        @(negedge clk);
        rmw_data_rdy = 0;
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_addr !== 16'h0304 || bus.mem_data_out !== 16'h2222) begin
            errors++; $display("FAIL hold_wb2: got ok=%b addr=%h data=%h expected 1 0304 2222", ok, bus.mem_addr, bus.mem_data_out);
        end
        bus_ack(16'h0000);
    endtask

    task automatic test_reset_mid();
        logic st;
        bit ok, seen;
        sched_op(0, 3'd3, 16'h0400, 16'h0000, st);
        sched_op(1, '0, 16'h0500, 16'h7777, st);
        sched_op(1, '0, 16'h0600, 16'h8888, st);
        checks++; if (state_dbg !== BUS_RD || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0400) begin
            errors++; $display("FAIL rmid_in_read: got state=%0d req=%b we=%b addr=%h expected %0d 1 0 0400", state_dbg, bus.mem_req, bus.mem_we, bus.mem_addr, BUS_RD);
        end
        #2 a_rst = 1;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || state_dbg !== IDLE) begin
            errors++; $display("FAIL rmid_drop: got req=%b state=%0d expected 0 %0d", bus.mem_req, state_dbg, IDLE);
        end
        @(negedge clk);
        a_rst = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_req || rf_wr) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got activity=%b expected 0", seen); end
        sched_op(0, 3'd4, 16'h0500, 16'h0000, st);
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL rmid_no_forward: got rf_wr=%b expected 0", rf_wr); end
        wait_mem_req(20, ok);
        checks++; if (!ok || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0500) begin
            errors++; $display("FAIL rmid_read: got ok=%b we=%b addr=%h expected 1 0 0500", ok, bus.mem_we, bus.mem_addr);
        end
        bus_ack(16'h1357);
        checks++; if (rf_wr !== 1'b1 || rf_tag !== 3'd4 || rf_data !== 16'h1357) begin
            errors++; $display("FAIL rmid_result: got wr=%b tag=%0d data=%h expected 1 4 1357", rf_wr, rf_tag, rf_data);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_fill();
        test_deny();
        test_priority();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
